// File: rtl/nonce_queue_pkg.sv
// Shared definitions for the nonce queue: nonce width, the encoding of the
// transmit FSM states, and a saturating add used by the drop counter.
package nonce_queue_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

  // Add a small per-cycle drop tally to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {4'b0000, b};
    if (sum[8]) begin
      sat_add8 = 8'hFF;
    end else begin
      sat_add8 = sum[7:0];
    end
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO for nonces.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset (pointers only)
//   i_push, i_wr_data   write request and data
//   i_pop,  o_rd_data   read request and head-of-queue data
//   o_full, o_empty     status flags
//   o_level             occupancy, 0 .. 2**DEPTH_LOG2
// Pointers are one bit wider than the address so full and empty are
// distinguished by the extra MSB. A push and a pop in the same cycle are both
// accepted when full or empty; when empty the write data is presented on
// o_rd_data directly so the popped value is the one being pushed.
module nonce_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

  // A pop frees the slot a full push needs; a push supplies the word an empty pop needs.
  assign w_do_push = i_push && (!o_full  || i_pop);
  assign w_do_pop  = i_pop  && (!o_empty || i_push);

  assign o_rd_data = o_empty ? i_wr_data : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/nonce_queue.sv
// Collects nonces from SLAVES hash cores and feeds them one at a time to the
// uplink serial transmitter.
// Ports:
//   clk, reset_n    hash clock, asynchronous active-low reset
//   slave_nonces    SLAVES packed 32-bit nonces, slave i on [i*32 +: 32]
//   new_nonces      one-cycle valid pulse per slave
//   tx_busy         transmitter busy
//   tx_send         one-cycle send request (registered)
//   tx_word         nonce being sent, held until the next tx_send (registered)
//   drop_count      saturating count of overwritten (lost) nonces
//   fifo_level      current FIFO occupancy
// Path: per-slave hold register -> round-robin grant -> FIFO -> transmit FSM.
module nonce_queue
  import nonce_queue_pkg::*;
#(
  parameter int SLAVES     = 2,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic [SLAVES-1:0]         new_nonces,
  input  logic                      tx_busy,
  output logic                      tx_send,
  output logic [NONCE_W-1:0]        tx_word,
  output logic [7:0]                drop_count,
  output logic [DEPTH_LOG2:0]       fifo_level
);

  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  logic [NONCE_W-1:0] r_hold [SLAVES];
  logic [SLAVES-1:0]  r_valid;
  logic [IDX_W-1:0]   r_last_grant;
  logic [7:0]         r_drop_count;
  logic               r_tx_send;
  logic [NONCE_W-1:0] r_tx_word;
  tx_state_e          r_state;
  tx_state_e          w_state_nxt;

  logic               w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [SLAVES-1:0]  w_grant_oh;
  logic [SLAVES-1:0]  w_drop;
  logic [4:0]         w_drop_num;
  logic [NONCE_W-1:0] w_push_data;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [NONCE_W-1:0] w_fifo_head;

  // Round-robin search starting one past the last winner; no grant while full.
  always_comb begin
    int v_idx;
    w_grant     = 1'b0;
    w_grant_idx = '0;
    v_idx       = 0;
    for (int k = 1; k <= SLAVES; k++) begin
      v_idx = int'(r_last_grant) + k;
      if (v_idx >= SLAVES) begin
        v_idx = v_idx - SLAVES;
      end else begin
        v_idx = v_idx;
      end
      if (!w_grant && !w_fifo_full && r_valid[v_idx[IDX_W-1:0]]) begin
        w_grant     = 1'b1;
        w_grant_idx = v_idx[IDX_W-1:0];
      end else begin
        // first winner found earlier in the search is kept
      end
    end
  end

  // A new nonce into a still-valid hold that is not being drained this cycle is a loss.
  always_comb begin
    w_grant_oh = '0;
    w_drop     = '0;
    w_drop_num = 5'd0;
    for (int i = 0; i < SLAVES; i++) begin
      w_grant_oh[i] = w_grant && (w_grant_idx == IDX_W'(i));
      w_drop[i]     = new_nonces[i] && r_valid[i] && !w_grant_oh[i];
      w_drop_num    = w_drop_num + {4'd0, w_drop[i]};
    end
  end

  assign w_push_data = r_hold[w_grant_idx];

  // Valid flags, arbiter pointer and drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid      <= '0;
      r_last_grant <= IDX_W'(SLAVES - 1);
      r_drop_count <= 8'd0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        // A new nonce wins over the grant so a coincident reload stays valid.
        if (new_nonces[i]) begin
          r_valid[i] <= 1'b1;
        end else if (w_grant_oh[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_grant) r_last_grant <= w_grant_idx;
      r_drop_count <= sat_add8(r_drop_count, w_drop_num);
    end
  end

  // Hold data capture; the old value is read for the push before this overwrite lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i]) r_hold[i] <= slave_nonces[i*NONCE_W +: NONCE_W];
    end
  end

  nonce_fifo #(
    .WIDTH      (NONCE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_grant),
    .i_wr_data (w_push_data),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_level   (fifo_level)
  );

  // Transmit FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transmit FSM next state. The pop is issued on the IDLE->LOAD edge so that
  // tx_send and tx_word are already registered for the single LOAD cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: w_state_nxt = ST_ACK;
      ST_ACK: begin
        if (tx_busy) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_DONE: begin
        if (!tx_busy) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered transmitter interface.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_send <= 1'b0;
      r_tx_word <= '0;
    end else begin
      r_tx_send <= w_pop;
      if (w_pop) r_tx_word <= w_fifo_head;
    end
  end

  assign tx_send    = r_tx_send;
  assign tx_word    = r_tx_word;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_nonce_queue.sv
module tb_nonce_queue;

  localparam int SLAVES     = 2;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] slave_nonces = 64'd0;
  logic [1:0]  new_nonces = 2'b00;
  logic        tx_busy = 1'b0;
  logic        tx_send;
  logic [31:0] tx_word;
  logic [7:0]  drop_count;
  logic [3:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nonce_queue #(.SLAVES(SLAVES), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .slave_nonces (slave_nonces),
    .new_nonces   (new_nonces),
    .tx_busy      (tx_busy),
    .tx_send      (tx_send),
    .tx_word      (tx_word),
    .drop_count   (drop_count),
    .fifo_level   (fifo_level)
  );

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_hold [SLAVES];
  bit          m_valid [SLAVES];
  int          m_last;
  logic [31:0] m_q [$];
  int          m_stage;   // 0 ready, 1 sending, 2 awaiting busy, 3 awaiting release
  bit          m_send;
  logic [31:0] m_word;
  int          m_drop;

  task automatic model_reset();
    for (int i = 0; i < SLAVES; i++) begin m_valid[i] = 0; m_hold[i] = '0; end
    m_last = SLAVES - 1; m_q.delete(); m_stage = 0;
    m_send = 0; m_word = '0; m_drop = 0;
  endtask

  task automatic model_step();
    int g; bit pop;
    g = -1;
    if (m_q.size() < DEPTH)
      for (int k = 1; k <= SLAVES; k++) begin
        int idx; idx = (m_last + k) % SLAVES;
        if (g < 0 && m_valid[idx]) g = idx;
      end
    pop = (m_stage == 0) && (m_q.size() > 0) && !tx_busy;
    m_send = pop;
    if (pop) m_word = m_q.pop_front();
    case (m_stage)
      0: if (pop) m_stage = 1;
      1: m_stage = 2;
      2: if (tx_busy) m_stage = 3;
      3: if (!tx_busy) m_stage = 0;
      default: m_stage = 0;
    endcase
    if (g >= 0) begin m_q.push_back(m_hold[g]); m_valid[g] = 0; m_last = g; end
    for (int i = 0; i < SLAVES; i++)
      if (new_nonces[i]) begin
        if (m_valid[i]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        m_hold[i] = slave_nonces[i*32 +: 32];
        m_valid[i] = 1;
      end
  endtask

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; new_nonces = 2'b00; tx_busy = 1'b0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
  endtask

  // Wait (bounded) for a tx_send, capture the word, then run one busy handshake.
  task automatic get_tx(output logic [31:0] word, output bit found);
    found = 0; word = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (tx_send === 1'b1) begin found = 1; word = tx_word; end
    end
    if (found) begin tx_busy = 1'b1; tick(); tick(); tx_busy = 1'b0; tick(); end
  endtask

  task automatic pulse(input logic [1:0] mask, input logic [31:0] d0, input logic [31:0] d1);
    slave_nonces = {d1, d0}; new_nonces = mask; tick(); new_nonces = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; tick();
    n_tests++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
    n_tests++; if (tx_word !== 32'd0) begin n_fail++; $display("FAIL reset_tx_word: got %h want 0", tx_word); end
    n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_single_nonce();
    int lat;
    do_reset();
    pulse(2'b01, 32'hDEADBEEF, 32'h0);
    lat = 1;
    while (tx_send !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", lat); end
    n_tests++; if (tx_word !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_word: got %h want deadbeef", tx_word); end
    tick();
    n_tests++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b want 0", tx_send); end
    tx_busy = 1'b1; tick(); tx_busy = 1'b0; tick();
    n_tests++; if (tx_word !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_word_hold: got %h want deadbeef", tx_word); end
    n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL single_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] w; bit f;
    logic [31:0] exp_w [6];
    exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h0};
    do_reset();
    pulse(2'b11, 32'h11111111, 32'h22222222);
    for (int k = 0; k < 2; k++) begin
      get_tx(w, f);
      n_tests++; if (!f || w !== exp_w[k]) begin n_fail++; $display("FAIL simul_order%0d: got %h found %0d want %h", k, w, f, exp_w[k]); end
    end
    // slave0 alone wins last; a joint pulse must now start from slave1
    pulse(2'b01, 32'h33333333, 32'h0);
    get_tx(w, f);
    n_tests++; if (!f || w !== exp_w[2]) begin n_fail++; $display("FAIL simul_single: got %h want %h", w, exp_w[2]); end
    pulse(2'b11, 32'h55555555, 32'h44444444);
    for (int k = 3; k < 5; k++) begin
      get_tx(w, f);
      n_tests++; if (!f || w !== exp_w[k]) begin n_fail++; $display("FAIL simul_rotate%0d: got %h found %0d want %h", k, w, f, exp_w[k]); end
    end
    n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL simul_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_overwrite();
    logic [31:0] w, e; bit f;
    do_reset();
    tx_busy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pulse(2'b01, 32'hA0000000 + k, 32'h0); tick();
      n_tests++; if (fifo_level !== 4'(k + 1)) begin n_fail++; $display("FAIL ovw_fill%0d: got %0d want %0d", k, fifo_level, k + 1); end
    end
    pulse(2'b10, 32'h0, 32'hB1B1B1B1);
    pulse(2'b10, 32'h0, 32'hB2B2B2B2);
    tick();
    n_tests++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovw_drop: got %0d want 1", drop_count); end
    n_tests++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovw_level: got %0d want 8", fifo_level); end
    tx_busy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      e = (k < 8) ? 32'hA0000000 + k : 32'hB2B2B2B2;
      get_tx(w, f);
      n_tests++; if (!f || w !== e) begin n_fail++; $display("FAIL ovw_drain%0d: got %h found %0d want %h", k, w, f, e); end
    end
    n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL ovw_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] w, e; bit f;
    do_reset();
    tx_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pulse(2'b01, 32'hC0000000 + k, 32'h0); tick(); tick(); tick();
      n_tests++; if (fifo_level !== 4'((k < 8) ? k + 1 : 8)) begin n_fail++; $display("FAIL full_level%0d: got %0d want %0d", k, fifo_level, (k < 8) ? k + 1 : 8); end
    end
    n_tests++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL full_drop: got %0d want 1", drop_count); end
    tx_busy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      e = (k < 8) ? 32'hC0000000 + k : 32'hC0000009;
      get_tx(w, f);
      n_tests++; if (!f || w !== e) begin n_fail++; $display("FAIL full_drain%0d: got %h found %0d want %h", k, w, f, e); end
    end
  endtask

  task automatic test_handshake();
    logic [31:0] w; bit f; int sends;
    do_reset();
    slave_nonces[31:0] = 32'hD0D0D0D0; new_nonces = 2'b01; tick();
    // back-to-back: second pulse coincides with the grant of the first
    slave_nonces[31:0] = 32'hD1D1D1D1; tick(); new_nonces = 2'b00;
    f = 0;
    for (int i = 0; i < 20 && !f; i++) begin if (tx_send === 1'b1) f = 1; else tick(); end
    n_tests++; if (!f || tx_word !== 32'hD0D0D0D0) begin n_fail++; $display("FAIL hs_first: got %h found %0d want d0d0d0d0", tx_word, f); end
    sends = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (tx_send === 1'b1) sends++; end
    n_tests++; if (sends !== 0) begin n_fail++; $display("FAIL hs_stall: got %0d sends want 0", sends); end
    n_tests++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL hs_level: got %0d want 1", fifo_level); end
    n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL hs_coincide_drop: got %0d want 0", drop_count); end
    tx_busy = 1'b1; tick(); tx_busy = 1'b0;
    get_tx(w, f);
    n_tests++; if (!f || w !== 32'hD1D1D1D1) begin n_fail++; $display("FAIL hs_second: got %h found %0d want d1d1d1d1", w, f); end
  endtask

  task automatic test_reset_mid();
    int sends;
    do_reset();
    tx_busy = 1'b1;
    pulse(2'b11, 32'hE0E0E0E0, 32'hE1E1E1E1);
    pulse(2'b11, 32'hE2E2E2E2, 32'hE3E3E3E3);
    tick(); tick();
    pulse(2'b01, 32'hE4E4E4E4, 32'h0); tick();
    pulse(2'b01, 32'hE5E5E5E5, 32'h0); tick();
    n_tests++; if (fifo_level !== 4'd5) begin n_fail++; $display("FAIL rmid_pre_level: got %0d want 5", fifo_level); end
    n_tests++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL rmid_pre_drop: got %0d want 1", drop_count); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", fifo_level); end
    n_tests++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_send: got %b want 0", tx_send); end
    n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rmid_drop: got %0d want 0", drop_count); end
    tick(); tick();
    reset_n = 1'b1; tx_busy = 1'b0;
    sends = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (tx_send === 1'b1) sends++; end
    n_tests++; if (sends !== 0) begin n_fail++; $display("FAIL rmid_no_tx: got %0d sends want 0", sends); end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    tx_busy = 1'b1;
    for (int k = 0; k < 8; k++) begin pulse(2'b01, 32'hF0000000 + k, 32'h0); tick(); end
    slave_nonces[31:0] = 32'hFFFF0000;
    new_nonces = 2'b01;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 254) begin
        n_tests++; if (drop_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", drop_count); end
      end
    end
    new_nonces = 2'b00;
    n_tests++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", drop_count); end
  endtask

  task automatic test_random();
    int busy_pct;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      busy_pct = ((cyc / 250) % 3 == 0) ? 10 : (((cyc / 250) % 3 == 1) ? 50 : 90);
      slave_nonces = {$urandom(), $urandom()};
      new_nonces   = {($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 25)};
      tx_busy      = ($urandom_range(0, 99) < busy_pct);
      tick();
      n_tests++; if (tx_send !== m_send) begin n_fail++; $display("FAIL rnd_send@%0d: got %b want %b", cyc, tx_send, m_send); end
      n_tests++; if (tx_word !== m_word) begin n_fail++; $display("FAIL rnd_word@%0d: got %h want %h", cyc, tx_word, m_word); end
      n_tests++; if (fifo_level !== 4'(m_q.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d want %0d", cyc, fifo_level, m_q.size()); end
      n_tests++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop@%0d: got %0d want %0d", cyc, drop_count, m_drop); end
    end
    new_nonces = 2'b00; tx_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_nonce();
    test_simultaneous();
    test_overwrite();
    test_fifo_full();
    test_handshake();
    test_reset_mid();
    test_drop_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/nonce_queue.md
NONCE_QUEUE -- requirements
Module: nonce_queue

Interface
REQ-001 SHALL have parameter SLAVES, default 2, meaning number of nonce sources (1..16).
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of the FIFO depth, 8 entries at the default.
REQ-003 SHALL have port clk  input  1  hash clock; all state rises on posedge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port slave_nonces  input  SLAVES*32  nonce of slave i on bits [i*32+31:i*32].
REQ-006 SHALL have port new_nonces  input  SLAVES  one-cycle pulse per slave: the matching slave_nonces slice is valid.
REQ-007 SHALL have port tx_busy  input  1  uplink serial transmitter busy.
REQ-008 SHALL have port tx_send  output  1  one-cycle request to the transmitter.
REQ-009 SHALL have port tx_word  output  32  nonce to transmit; stable from the tx_send cycle until the next tx_send.
REQ-010 SHALL have port drop_count  output  8  saturating count of nonces lost.
REQ-011 SHALL have port fifo_level  output  DEPTH_LOG2+1  current FIFO occupancy.

Function
REQ-012 SHALL give each slave a hold register plus a valid flag; a new_nonces[i] pulse loads slice i and sets valid[i].
REQ-013 SHALL, when new_nonces[i] arrives while valid[i]=1 and hold i is not granted that cycle, overwrite with the newer nonce and increment drop_count.
REQ-014 SHALL, when new_nonces[i] coincides with a grant of hold i, push the old value, load the new value, and keep valid[i]=1, with no drop.
REQ-015 SHALL use a round-robin arbiter that grants at most one valid hold per cycle, only when the FIFO is not full, searching from index last_grant+1 with wrap at SLAVES-1 to 0.
REQ-016 SHALL push the granted hold into the FIFO in the same cycle and clear its valid flag.
REQ-017 SHALL implement the FIFO as 2**DEPTH_LOG2 entries of 32 bits with wrapping read/write pointers one bit wider than the address; full when the MSBs differ and the rest are equal.
REQ-018 SHALL accept a simultaneous push and pop when full or empty without changing fifo_level.
REQ-019 SHALL drive the transmit FSM as follows.
  - IDLE -> LOAD when FIFO is non-empty and tx_busy=0.
  - LOAD: pop the head into tx_word and assert tx_send for exactly 1 cycle -> ACK.
  - ACK: wait for tx_busy=1 -> DONE.
  - DONE: wait for tx_busy=0 -> IDLE.
REQ-020 SHALL give one nonce a latency of 3 cycles from new_nonces pulse to tx_send, with the FIFO empty and the FSM idle: hold, FIFO, LOAD.
REQ-021 SHALL give drop_count 8 bits that saturate at 255 and never wrap.
REQ-022 SHALL transmit every nonce exactly once, in FIFO order, provided there are no drops.

Reset
REQ-023 SHALL, on reset_n=0 and asynchronously, clear all valid flags, the FIFO pointers, last_grant (to SLAVES-1), drop_count, tx_send and tx_word, and set the FSM to IDLE.
REQ-024 SHALL discard queued nonces on reset mid-transfer; the transmitter completes its own frame independently.
REQ-025 SHALL release reset so that the first new_nonces pulse seen on the cycle after deassertion is captured.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE, LOAD, ACK, DONE) and the nonce width constant (32) in the shared miner package.
REQ-027 SHALL build the FIFO as one sub-module, nonce_fifo, parameterised by width and DEPTH_LOG2; arbiter and FSM stay in nonce_queue.

Verification
REQ-028 SHALL cover single nonce: pulse slave0 with 0xDEADBEEF and tx_busy idle -> tx_send 3 cycles later with tx_word=0xDEADBEEF, and drop_count=0.
REQ-029 SHALL cover simultaneous slaves: pulse slave0=0x11111111 and slave1=0x22222222 in the same cycle -> two transmissions in order 0x11111111 then 0x22222222; repeat the pulse -> order rotates after the grant.
REQ-030 SHALL cover overwrite: pulse slave1 twice back-to-back while the FIFO is full -> only the second value is queued and drop_count=1.
REQ-031 SHALL cover FIFO full: hold tx_busy=1 and inject 10 nonces from slave0 at 4-cycle spacing -> fifo_level stops at 8, the excess goes to the hold or is dropped, and drop_count=1.
REQ-032 SHALL cover the handshake: hold tx_busy=0 after tx_send -> FSM stays in ACK with no second tx_send; raise then lower tx_busy -> next tx_send follows.
REQ-033 SHALL cover reset mid-operation: assert reset_n=0 with 5 nonces queued -> fifo_level=0, tx_send=0 and drop_count=0 immediately, and no further transmissions.
